// File: rtl/xor_pkg.sv
// Shared types and constants for the xor_accumulator block.
package xor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam logic MODE_PAIR = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

endpackage

// File: rtl/xor_accumulator_if.sv
// Operand/result stream bundle for xor_accumulator; master drives beats and consumes results.
interface xor_accumulator_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y;
  logic             par;
  logic [CNT_W-1:0] cnt;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, mode, in_last, in_valid, out_ready,
    input  in_ready, y, par, cnt, out_valid
  );

  modport slave (
    input  a, b, mode, in_last, in_valid, out_ready,
    output in_ready, y, par, cnt, out_valid
  );
endinterface

// File: rtl/xor_parity.sv
// XOR-reduction of a WIDTH-bit word: par = 1 when the word has an odd number of ones.
module xor_parity #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             par
);

  assign par = ^data;

endmodule

// File: rtl/xor_accumulator.sv
// Registered pairwise / framed-accumulate XOR engine with valid/ready on both sides.
// Build option: define XOR_ACC_PARITY_EN to compute PAR; otherwise PAR is tied to 0.
//
// state | meaning
// IDLE  | no accumulate frame open; pairwise and single-beat frames complete here
// ACC   | accumulate frame open; acc/count hold the partial result
module xor_accumulator
  import xor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  xor_accumulator_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] beat_x;
  logic [CNT_W-1:0] count_inc;

  // Ready never looks at in_valid, so upstream can't form a combinational loop through us.
  assign in_ready  = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && in_ready;
  assign beat_x    = bus.a ^ bus.b;
  assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q && !bus.out_ready;

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (bus.mode == MODE_PAIR || bus.in_last) begin
            y_d         = beat_x;
            cnt_d       = CNT_ONE;
            out_valid_d = 1'b1;
          end else begin
            acc_d   = beat_x;
            count_d = CNT_ONE;
            state_d = ACC;
          end
        end
        ACC: begin
          // mode is deliberately ignored once a frame is open
          if (!bus.in_last) begin
            acc_d   = acc_q ^ beat_x;
            count_d = count_inc;
          end else begin
            y_d         = acc_q ^ beat_x;
            cnt_d       = count_inc;
            out_valid_d = 1'b1;
            acc_d       = '0;
            count_d     = '0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef XOR_ACC_PARITY_EN
  logic par_d;
  logic par_q;

  // Parity follows y_d so it is always registered together with the value it describes.
  xor_parity #(.WIDTH(WIDTH)) u_parity (
    .data (y_d),
    .par  (par_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign bus.par = par_q;
`else
  assign bus.par = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.y         = y_q;
  assign bus.cnt       = cnt_q;
  assign bus.out_valid = out_valid_q;

endmodule
